// File: rtl/ffnn_pkg.sv
// ----------------------------------------------------------------------------
// ffnn_pkg
// Shared definitions for the FeedForwardNN sequencer.
//   - state_t and the three FSM state codes (2-bit, legacy-compatible)
//   - WWIDTH_DEF  : default base word width
//   - LATENCY_MIN / LATENCY_MAX : legal bounds of the datapath latency
// No ports (package).
// ----------------------------------------------------------------------------
package ffnn_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_HOLD = 2'd2;

  localparam int WWIDTH_DEF  = 32;
  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 255;

endpackage

// File: rtl/ffnn_sequencer.sv
// ----------------------------------------------------------------------------
// ffnn_sequencer
// Feeds one input vector at a time into a fixed-latency FeedForwardNN
// datapath, waits LATENCY cycles, captures its two results and offers them
// on a valid/ready handshake. Only one sample is ever in flight.
//
// Ports
//   CLK                 clock, rising edge
//   RST                 synchronous active-low reset
//   in_valid/in_ready   input-vector handshake
//   in_x0..in_x3        input features (WWIDTH+1 signed)
//   nn_x0..nn_x3        registered drive to the NN inputs
//   nn_rst              active-high NN reset (RST low plus one cycle)
//   nn_y0, nn_y1        NN results (2*WWIDTH+1 signed)
//   out_valid/out_ready result handshake
//   out_y0, out_y1      captured results
//   busy                FSM not in IDLE
//   sample_cnt          results transferred since reset (wraps)
//
// Configuration
//   FFNN_SEQ_CNT_EN     when defined the sample counter is built; otherwise
//                       sample_cnt is tied to zero.
// ----------------------------------------------------------------------------
module ffnn_sequencer
  import ffnn_pkg::*;
#(
  parameter int WWIDTH  = WWIDTH_DEF,
  parameter int LATENCY = 24,
  parameter int CNTW    = 16
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [WWIDTH:0]    in_x0,
  input  logic signed [WWIDTH:0]    in_x1,
  input  logic signed [WWIDTH:0]    in_x2,
  input  logic signed [WWIDTH:0]    in_x3,
  output logic signed [WWIDTH:0]    nn_x0,
  output logic signed [WWIDTH:0]    nn_x1,
  output logic signed [WWIDTH:0]    nn_x2,
  output logic signed [WWIDTH:0]    nn_x3,
  output logic                      nn_rst,
  input  logic signed [2*WWIDTH:0]  nn_y0,
  input  logic signed [2*WWIDTH:0]  nn_y1,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [2*WWIDTH:0]  out_y0,
  output logic signed [2*WWIDTH:0]  out_y1,
  output logic                      busy,
  output logic [CNTW-1:0]           sample_cnt
);

  // Out-of-range latencies are clamped so the 8-bit wait counter stays valid.
  localparam int LAT_C = (LATENCY < LATENCY_MIN) ? LATENCY_MIN :
                         ((LATENCY > LATENCY_MAX) ? LATENCY_MAX : LATENCY);
  localparam logic [7:0] CNT_LOAD = 8'(LAT_C - 1);

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [7:0]               r_cnt;
  logic                     r_in_ready;
  logic                     r_out_valid;
  logic                     r_busy;
  logic                     r_nn_rst;
  logic signed [WWIDTH:0]   r_nn_x0, r_nn_x1, r_nn_x2, r_nn_x3;
  logic signed [2*WWIDTH:0] r_out_y0, r_out_y1;
  logic                     w_accept;
  logic                     w_capture;

  // Next-state decode and the accept/capture strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // r_in_ready is low in the first cycle after reset, so nothing is
        // accepted while the NN is still held in reset.
        if (in_valid && r_in_ready) begin
          w_state_nxt = ST_WAIT;
          w_accept    = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (r_cnt == 8'd0) begin
          w_state_nxt = ST_HOLD;
          w_capture   = 1'b1;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_HOLD;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM, wait counter, data registers and status flags.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 8'd0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_nn_rst    <= 1'b1;
      r_nn_x0     <= '0;
      r_nn_x1     <= '0;
      r_nn_x2     <= '0;
      r_nn_x3     <= '0;
      r_out_y0    <= '0;
      r_out_y1    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_nn_rst    <= 1'b0;
      // Flags follow the next state so they are registered, not decoded.
      r_in_ready  <= (w_state_nxt == ST_IDLE);
      r_out_valid <= (w_state_nxt == ST_HOLD);
      r_busy      <= (w_state_nxt != ST_IDLE);
      if (w_accept) begin
        r_nn_x0 <= in_x0;
        r_nn_x1 <= in_x1;
        r_nn_x2 <= in_x2;
        r_nn_x3 <= in_x3;
        r_cnt   <= CNT_LOAD;
      end else if ((r_state == ST_WAIT) && (r_cnt != 8'd0)) begin
        r_cnt <= r_cnt - 8'd1;
      end else begin
        r_cnt <= r_cnt;
      end
      if (w_capture) begin
        r_out_y0 <= nn_y0;
        r_out_y1 <= nn_y1;
      end else begin
        r_out_y0 <= r_out_y0;
        r_out_y1 <= r_out_y1;
      end
    end
  end

`ifdef FFNN_SEQ_CNT_EN
  logic            w_transfer;
  logic [CNTW-1:0] r_sample_cnt;

  assign w_transfer = (r_state == ST_HOLD) && out_ready;

  // Transferred-result counter; wraps naturally at 2^CNTW.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_sample_cnt <= '0;
    end else if (w_transfer) begin
      r_sample_cnt <= r_sample_cnt + CNTW'(1);
    end else begin
      r_sample_cnt <= r_sample_cnt;
    end
  end

  assign sample_cnt = r_sample_cnt;
`else
  assign sample_cnt = '0;
`endif

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign nn_rst    = r_nn_rst;
  assign nn_x0     = r_nn_x0;
  assign nn_x1     = r_nn_x1;
  assign nn_x2     = r_nn_x2;
  assign nn_x3     = r_nn_x3;
  assign out_y0    = r_out_y0;
  assign out_y1    = r_out_y1;

endmodule

// File: tb/tb_ffnn_sequencer.sv
// ----------------------------------------------------------------------------
// tb_ffnn_sequencer
// Randomised and directed stimulus for ffnn_sequencer with a transaction-level
// reference model (acceptance cycle + LATENCY arithmetic) compared every cycle,
// plus literal expectations for reset, the (5,-3,7,0) sample, backpressure,
// mid-operation abort and counter wrap (CNTW=4).
// ----------------------------------------------------------------------------
module tb_ffnn_sequencer;

  localparam int WW  = 32;
  localparam int LAT = 24;
  localparam int CW  = 4;
  localparam int XW  = WW + 1;
  localparam int YW  = 2 * WW + 1;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready, nn_rst, out_valid, busy;
  logic signed [XW-1:0] in_x0 = '0, in_x1 = '0, in_x2 = '0, in_x3 = '0;
  logic signed [XW-1:0] nn_x0, nn_x1, nn_x2, nn_x3;
  logic signed [YW-1:0] nn_y0 = '0, nn_y1 = '0;
  logic signed [YW-1:0] out_y0, out_y1;
  logic [CW-1:0] sample_cnt;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  logic signed [YW-1:0] last_y0, last_y1;

  ffnn_sequencer #(.WWIDTH(WW), .LATENCY(LAT), .CNTW(CW)) dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x0(in_x0), .in_x1(in_x1), .in_x2(in_x2), .in_x3(in_x3),
    .nn_x0(nn_x0), .nn_x1(nn_x1), .nn_x2(nn_x2), .nn_x3(nn_x3),
    .nn_rst(nn_rst),
    .nn_y0(nn_y0), .nn_y1(nn_y1),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y0(out_y0), .out_y1(out_y1),
    .busy(busy), .sample_cnt(sample_cnt)
  );

  always #5 CLK = ~CLK;

  function automatic logic signed [XW-1:0] rnd_x();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[XW-1:0];
  endfunction

  function automatic logic signed [YW-1:0] rnd_y();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[YW-1:0];
  endfunction

  // Expected counter value after n transfers.
  function automatic logic [CW-1:0] exp_cnt(int n);
`ifdef FFNN_SEQ_CNT_EN
    return CW'(n % (1 << CW));
`else
    return CW'(0);
`endif
  endfunction

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // One cycle: advance to the falling edge, then present new NN results.
  task automatic tick();
    @(negedge CLK);
    last_y0 = nn_y0;
    last_y1 = nn_y1;
    nn_y0 = rnd_y();
    nn_y1 = rnd_y();
  endtask

  task automatic rand_x();
    in_x0 = rnd_x(); in_x1 = rnd_x(); in_x2 = rnd_x(); in_x3 = rnd_x();
  endtask

  // ---------------- reference model (transaction level) ----------------
  int  cyc = 0;
  int  m_acc = 0;
  int  m_cnt = 0;
  bit  m_rdy = 1'b0, m_inflight = 1'b0, m_hold = 1'b0, m_nnrst = 1'b1;
  logic signed [XW-1:0] m_x0 = '0, m_x1 = '0, m_x2 = '0, m_x3 = '0;
  logic signed [YW-1:0] m_y0 = '0, m_y1 = '0;

  always @(posedge CLK) begin
    cyc = cyc + 1;
    if (!RST) begin
      m_rdy = 1'b0; m_inflight = 1'b0; m_hold = 1'b0; m_nnrst = 1'b1;
      m_x0 = '0; m_x1 = '0; m_x2 = '0; m_x3 = '0;
      m_y0 = '0; m_y1 = '0; m_cnt = 0;
    end else begin
      m_nnrst = 1'b0;
      if (m_hold) begin
        if (out_ready) begin
          m_hold = 1'b0; m_rdy = 1'b1; m_cnt = m_cnt + 1;
        end
      end else if (m_inflight) begin
        // Results are taken exactly LAT edges after the accepting edge.
        if (cyc == m_acc + LAT) begin
          m_inflight = 1'b0; m_hold = 1'b1; m_y0 = nn_y0; m_y1 = nn_y1;
        end
      end else if (m_rdy) begin
        if (in_valid) begin
          m_rdy = 1'b0; m_inflight = 1'b1; m_acc = cyc;
          m_x0 = in_x0; m_x1 = in_x1; m_x2 = in_x2; m_x3 = in_x3;
        end
      end else begin
        m_rdy = 1'b1;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge CLK) begin
    if (chk_en) begin
      chk("in_ready",   in_ready,   m_rdy);
      chk("out_valid",  out_valid,  m_hold);
      chk("busy",       busy,       m_inflight | m_hold);
      chk("nn_rst",     nn_rst,     m_nnrst);
      chk("nn_x0",      nn_x0,      m_x0);
      chk("nn_x1",      nn_x1,      m_x1);
      chk("nn_x2",      nn_x2,      m_x2);
      chk("nn_x3",      nn_x3,      m_x3);
      chk("out_y0",     out_y0,     m_y0);
      chk("out_y1",     out_y1,     m_y1);
      chk("sample_cnt", sample_cnt, exp_cnt(m_cnt));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int k;
    int n;
    logic signed [YW-1:0] sy0, sy1;

    // Reset for three cycles.
    RST = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    tick();
    chk("rst_in_ready",  in_ready,   1'b0);
    chk("rst_nn_rst",    nn_rst,     1'b1);
    chk("rst_out_valid", out_valid,  1'b0);
    chk("rst_busy",      busy,       1'b0);
    chk("rst_cnt",       sample_cnt, 4'd0);
    chk("rst_nn_x0",     nn_x0,      33'sd0);
    chk("rst_out_y0",    out_y0,     65'sd0);
    RST = 1'b1;
    chk("post_rst_nn_rst", nn_rst, 1'b1);
    tick();
    chk("nn_rst_low",   nn_rst,   1'b0);
    chk("ready_up",     in_ready, 1'b1);

    // Abort with the wait counter at 10.
    rand_x();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("abort_busy", busy, 1'b1);
    repeat (13) tick();
    RST = 1'b0;
    tick();
    RST = 1'b1;
    chk("abort_out_valid", out_valid,  1'b0);
    chk("abort_busy_low",  busy,       1'b0);
    chk("abort_cnt",       sample_cnt, 4'd0);
    tick();
    chk("abort_ready", in_ready, 1'b1);

    // Directed sample (5,-3,7,0).
    in_x0 = 33'sd5; in_x1 = -33'sd3; in_x2 = 33'sd7; in_x3 = 33'sd0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("dir_nn_x0", nn_x0, 33'sd5);
    chk("dir_nn_x1", nn_x1, -33'sd3);
    chk("dir_nn_x2", nn_x2, 33'sd7);
    chk("dir_nn_x3", nn_x3, 33'sd0);
    k = 1;
    while (out_valid !== 1'b1 && k < 100) begin
      tick();
      k++;
    end
    chk("dir_latency", k, 25);
    chk("dir_y0", out_y0, last_y0);
    chk("dir_y1", out_y1, last_y1);

    // Backpressure: ten HOLD cycles with in_valid pulses and changing nn_y.
    sy0 = out_y0;
    sy1 = out_y1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'($urandom % 2);
      rand_x();
      tick();
      chk("bp_y0", out_y0, sy0);
      chk("bp_y1", out_y1, sy1);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_out_valid", out_valid, 1'b1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_done_valid", out_valid, 1'b0);
    chk("bp_done_ready", in_ready, 1'b1);
    chk("bp_cnt", sample_cnt, exp_cnt(1));
    chk("bp_x_kept", nn_x1, -33'sd3);

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      in_valid  = 1'($urandom % 2);
      out_ready = 1'($urandom % 2);
      rand_x();
      RST = ($urandom % 150) != 0;
      tick();
    end

    // Clean restart, then back-to-back samples.
    RST = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    RST = 1'b1;
    tick();
    out_ready = 1'b1;
    in_valid = 1'b1;
    n = 0;
    for (int s = 0; s < 100; s++) begin
      k = 0;
      while (in_ready !== 1'b1 && k < 50) begin
        tick();
        k++;
      end
      chk("b2b_ready_wait", (k < 50), 1'b1);
      rand_x();
      tick();
      k = 1;
      while (out_valid !== 1'b1 && k < 100) begin
        tick();
        k++;
      end
      chk("b2b_latency", (k <= 26), 1'b1);
      tick();
      n++;
      if (n == 17) begin
`ifdef FFNN_SEQ_CNT_EN
        chk("cnt_wrap17", sample_cnt, 4'd1);
`else
        chk("cnt_off17", sample_cnt, 4'd0);
`endif
      end
    end
    in_valid = 1'b0;
`ifdef FFNN_SEQ_CNT_EN
    chk("cnt_100", sample_cnt, 4'd4);
`else
    chk("cnt_off100", sample_cnt, 4'd0);
`endif
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ffnn_sequencer.md
FFNN_SEQUENCER -- requirements
Module: ffnn_sequencer

Interface
REQ-001 Parameter WWIDTH, default 32: base word width; NN inputs are WWIDTH+1 bits signed, NN outputs 2*WWIDTH+1 bits signed.
REQ-002 Parameter LATENCY, default 24: clock cycles the FeedForwardNN datapath needs from stable inputs to valid outputs; legal range 1..255.
REQ-003 Parameter CNTW, default 16: width of the sample counter.
REQ-004 CLK  in  1  single clock; all state updates on rising edge.
REQ-005 RST  in  1  reset, synchronous, active-low.
REQ-006 in_valid in 1, in_ready out 1: input-vector handshake; transfer when both high on a rising edge.
REQ-007 in_x0..in_x3  in  WWIDTH+1 signed each: input feature vector.
REQ-008 nn_x0..nn_x3  out  WWIDTH+1 signed each: registered drive to the FeedForwardNN x0..x3 ports.
REQ-009 nn_rst  out  1  active-high reset to the FeedForwardNN RST port.
REQ-010 nn_y0, nn_y1  in  2*WWIDTH+1 signed each: FeedForwardNN results.
REQ-011 out_valid out 1, out_ready in 1: result handshake; transfer when both high on a rising edge.
REQ-012 out_y0, out_y1  out  2*WWIDTH+1 signed each: captured results.
REQ-013 busy  out  1  high whenever state is not IDLE.
REQ-014 sample_cnt  out  CNTW  number of results transferred since reset.

Function
REQ-015 The FSM SHALL have three states, encoded 2 bits: IDLE, WAIT, HOLD.
REQ-016 IDLE: in_ready=1; on in_valid, latch in_x0..3 into nn_x0..3, load the wait counter with LATENCY-1, go to WAIT.
REQ-017 WAIT: in_ready=0; decrement the counter each cycle; in the cycle the counter is 0, capture nn_y0/nn_y1 into out_y0/out_y1 and go to HOLD.
REQ-018 HOLD: out_valid=1, out_y0/out_y1 stable; on out_ready go to IDLE and increment sample_cnt.
REQ-019 Input accepted on edge t SHALL yield out_valid high from the cycle after edge t+LATENCY (LATENCY+1 cycles of busy before HOLD ends at the earliest).
REQ-020 nn_x0..3 SHALL stay constant from acceptance until the next acceptance; they are not cleared on return to IDLE.
REQ-021 Only one sample in flight; in_ready SHALL be 0 in WAIT and HOLD, including the HOLD cycle in which out_ready is high (no same-cycle re-accept).
REQ-022 in_valid while in_ready=0 SHALL be ignored; inputs are not sampled.
REQ-023 out_y0/out_y1 SHALL be unchanged outside the WAIT-to-HOLD capture cycle.
REQ-024 sample_cnt SHALL wrap from 2^CNTW-1 to 0.
REQ-025 No arithmetic is performed on data; widths pass through unchanged, sign preserved.

Reset
REQ-026 When RST=0 at an edge: state=IDLE, counter=0, nn_x0..3=0, out_y0/out_y1=0, out_valid=0, sample_cnt=0; in_ready reads 0 during reset cycles.
REQ-027 nn_rst SHALL be 1 while RST=0 and for exactly one cycle after RST returns high, then 0.
REQ-028 Reset asserted in WAIT or HOLD SHALL abort the sample with no result and no counter increment.

Configuration
REQ-029 Macro FFNN_SEQ_CNT_EN: when defined, sample_cnt behaves per REQ-014/018/024; when undefined, the counter register is not built and sample_cnt is tied to 0.

Structure
REQ-030 Package ffnn_pkg SHALL hold the FSM state typedef, default WWIDTH, and LATENCY bounds.
REQ-031 No sub-modules; the wait counter is inline.

Verification
REQ-032 Reset: RST=0 for 3 cycles, then 1 -> all outputs 0, nn_rst high through first post-reset cycle then low, in_ready=1 next cycle.
REQ-033 Single sample, LATENCY=24: x=(5,-3,7,0) accepted at edge t -> nn_x=(5,-3,7,0) after t, out_valid rises after edge t+24, out_y matches nn_y sampled then.
REQ-034 Backpressure: out_ready=0 for 10 cycles in HOLD, nn_y changing -> out_y stable, in_ready=0, in_valid pulses ignored.
REQ-035 Back-to-back 100 samples with out_ready=1 -> sample_cnt=100, each result within 26 cycles of acceptance.
REQ-036 Mid-operation reset at counter=10 -> IDLE, out_valid=0, sample_cnt unchanged at 0; with CNTW=4, 17 transfers -> sample_cnt=1.
REQ-037 Build without FFNN_SEQ_CNT_EN -> sample_cnt=0 after 5 transfers.
